spike_packetizer: RTL and testbench

//  PE-side injection stage feeding a mesh switch's PE input port (i_pe_valid/o_pe_ready/i_pe_data).
//  - Accepts neuron spike events from the neuron core.
//  - Buffers the events in a FIFO.
//  - Looks up a per-neuron multicast fan-out table.
//  - Emits one 42-bit unicast flit per enabled destination under a valid/ready handshake.

---
 rtl/noc_pkg.sv | 34 +++
 rtl/spike_fifo.sv | 54 +++++
 rtl/spike_packetizer.sv | 168 ++++++++++++++++
 tb/tb_spike_packetizer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, coordinate width and packetizer FSM states.
package noc_pkg;

    localparam int unsigned FLIT_W      = 42;
    localparam int unsigned COORD_W     = 4;
    localparam int unsigned TS_W        = 10;
    localparam int unsigned NID_FIELD_W = 16;
    localparam int unsigned CFG_W       = 1 + 2 * COORD_W;

    localparam int unsigned DST_X_LSB = 38;
    localparam int unsigned DST_Y_LSB = 34;
    localparam int unsigned SRC_X_LSB = 30;
    localparam int unsigned SRC_Y_LSB = 26;
    localparam int unsigned TS_LSB    = 16;
    localparam int unsigned NID_LSB   = 0;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StSend
    } pkt_state_e;

    function automatic logic [FLIT_W-1:0] make_flit(
        input logic [COORD_W-1:0]     dst_x,
        input logic [COORD_W-1:0]     dst_y,
        input logic [COORD_W-1:0]     src_x,
        input logic [COORD_W-1:0]     src_y,
        input logic [TS_W-1:0]        ts,
        input logic [NID_FIELD_W-1:0] nid
    );
        return {dst_x, dst_y, src_x, src_y, ts, nid};
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous FIFO for spike events; DEPTH must be a power of two so pointers wrap naturally.
module spike_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({i_push, i_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (i_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (i_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/spike_packetizer.sv
// Spike-to-flit injection stage: FIFO, per-neuron fan-out table, one unicast flit per enabled slot.
// Optional SPIKE_TIMESTAMP_EN carries a 10-bit acceptance timestamp in flit bits [25:16].
module spike_packetizer
    import noc_pkg::*;
#(
    parameter int unsigned MY_X       = 0,
    parameter int unsigned MY_Y       = 0,
    parameter int unsigned NID_W      = 6,
    parameter int unsigned FANOUT     = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_spk_valid,
    output logic                              o_spk_ready,
    input  logic [NID_W-1:0]                  i_spk_nid,
    input  logic                              i_cfg_we,
    input  logic [NID_W+$clog2(FANOUT)-1:0]   i_cfg_addr,
    input  logic [CFG_W-1:0]                  i_cfg_data,
    output logic                              o_flit_valid,
    input  logic                              i_flit_ready,
    output logic [FLIT_W-1:0]                 o_flit_data,
    output logic                              o_busy
);

    localparam int unsigned SLOT_W  = $clog2(FANOUT);
    localparam int unsigned ADDR_W  = NID_W + SLOT_W;
    localparam int unsigned ENTRIES = FANOUT << NID_W;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
`ifdef SPIKE_TIMESTAMP_EN
    localparam int unsigned FIFO_W  = NID_W + TS_W;
`else
    localparam int unsigned FIFO_W  = NID_W;
`endif

    logic              push, pop, fifo_full, fifo_empty;
    logic [FIFO_W-1:0] push_data, pop_data;
    logic [CNT_W-1:0]  fifo_count;
    logic [NID_W-1:0]  fifo_nid;
    logic [TS_W-1:0]   fifo_ts;

    assign push     = i_spk_valid && o_spk_ready;
    assign fifo_nid = pop_data[NID_W-1:0];

`ifdef SPIKE_TIMESTAMP_EN
    logic [TS_W-1:0] tcnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) tcnt_q <= '0;
        else       tcnt_q <= tcnt_q + 1'b1;
    end

    assign push_data = {tcnt_q, i_spk_nid};
    assign fifo_ts   = pop_data[FIFO_W-1:NID_W];
`else
    assign push_data = i_spk_nid;
    assign fifo_ts   = '0;
`endif

    spike_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (push_data),
        .i_pop   (pop),
        .o_data  (pop_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Fan-out table, addressed {nid, slot}; entry = {en, dst_x, dst_y}.
    logic [CFG_W-1:0] tbl_q [ENTRIES];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
        end else if (i_cfg_we) begin
            tbl_q[i_cfg_addr] <= i_cfg_data;
        end
    end

    pkt_state_e         state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [NID_W-1:0]   nid_q, nid_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               valid_q, valid_d;
    logic [FLIT_W-1:0]  flit_q, flit_d;
    logic [CFG_W-1:0]   cur_entry;
    logic               last_slot;

    assign cur_entry = tbl_q[ADDR_W'({nid_q, slot_q})];
    assign last_slot = (slot_q == SLOT_W'(FANOUT - 1));

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        nid_d   = nid_q;
        ts_d    = ts_q;
        valid_d = valid_q;
        flit_d  = flit_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    nid_d   = fifo_nid;
                    ts_d    = fifo_ts;
                    slot_d  = '0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (cur_entry[CFG_W-1]) begin
                    flit_d  = make_flit(cur_entry[2*COORD_W-1:COORD_W], cur_entry[COORD_W-1:0],
                                        COORD_W'(MY_X), COORD_W'(MY_Y), ts_q,
                                        NID_FIELD_W'(nid_q));
                    valid_d = 1'b1;
                    state_d = StSend;
                end else if (last_slot) begin
                    state_d = StIdle;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            StSend: begin
                // Flit is registered, so later table writes cannot disturb it.
                if (i_flit_ready) begin
                    valid_d = 1'b0;
                    if (last_slot) begin
                        state_d = StIdle;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = StScan;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            slot_q  <= '0;
            nid_q   <= '0;
            ts_q    <= '0;
            valid_q <= 1'b0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            nid_q   <= nid_d;
            ts_q    <= ts_d;
            valid_q <= valid_d;
            flit_q  <= flit_d;
        end
    end

    assign o_spk_ready  = !fifo_full;
    assign o_flit_valid = valid_q;
    assign o_flit_data  = flit_q;
    assign o_busy       = (state_q != StIdle) || (fifo_count != '0);

endmodule

// File: tb/tb_spike_packetizer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_spike_packetizer;

    localparam int unsigned MY_X   = 0;
    localparam int unsigned MY_Y   = 0;
    localparam int unsigned NID_W  = 6;
    localparam int unsigned FANOUT = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned SLOT_W = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    spk_valid = 1'b0;
    logic                    spk_ready;
    logic [NID_W-1:0]        spk_nid = '0;
    logic                    cfg_we = 1'b0;
    logic [NID_W+SLOT_W-1:0] cfg_addr = '0;
    logic [8:0]              cfg_data = '0;
    logic                    flit_valid;
    logic                    flit_ready = 1'b0;
    logic [41:0]             flit_data;
    logic                    busy;

    spike_packetizer #(
        .MY_X       (MY_X),
        .MY_Y       (MY_Y),
        .NID_W      (NID_W),
        .FANOUT     (FANOUT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_spk_valid  (spk_valid),
        .o_spk_ready  (spk_ready),
        .i_spk_nid    (spk_nid),
        .i_cfg_we     (cfg_we),
        .i_cfg_addr   (cfg_addr),
        .i_cfg_data   (cfg_data),
        .o_flit_valid (flit_valid),
        .i_flit_ready (flit_ready),
        .o_flit_data  (flit_data),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int xfer_cnt = 0;

    logic [8:0]  m_tbl [2**NID_W][FANOUT];
    logic [41:0] exp_q [$];
    logic [9:0]  tb_cyc = '0;
    logic        prev_stall = 1'b0;
    logic [41:0] prev_data = '0;
    logic        rdy_rand = 1'b0;
    logic        rdy_force = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) tb_cyc <= '0;
        else     tb_cyc <= tb_cyc + 10'd1;
    end

    always @(posedge clk) begin
        #2;
        flit_ready = rdy_rand ? ($urandom_range(3) != 0) : rdy_force;
    end

    // Reference model: each accepted spike expands to one flit per enabled slot, in slot order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            for (int n = 0; n < 2**NID_W; n++)
                for (int s = 0; s < FANOUT; s++) m_tbl[n][s] = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(flit_valid), 64'd1);
                check("hold_data", 64'(flit_data), 64'(prev_data));
            end
            if (cfg_we) m_tbl[cfg_addr[NID_W+SLOT_W-1:SLOT_W]][cfg_addr[SLOT_W-1:0]] = cfg_data;
            if (spk_valid && spk_ready) begin
                logic [9:0] ts;
`ifdef SPIKE_TIMESTAMP_EN
                ts = tb_cyc;
`else
                ts = '0;
`endif
                for (int s = 0; s < FANOUT; s++) begin
                    logic [8:0] e;
                    e = m_tbl[spk_nid][s];
                    if (e[8]) exp_q.push_back({e[7:4], e[3:0], 4'(MY_X), 4'(MY_Y), ts,
                                               16'(spk_nid)});
                end
            end
            if (flit_valid && flit_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) check("unexpected_flit", 64'(flit_data), 64'd0);
                else                   check("flit", 64'(flit_data), 64'(exp_q.pop_front()));
            end
            prev_stall = flit_valid && !flit_ready;
            prev_data  = flit_data;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int nid, input int slot, input logic [8:0] data);
        cfg_we   = 1'b1;
        cfg_addr = {NID_W'(nid), SLOT_W'(slot)};
        cfg_data = data;
        align();
        cfg_we = 1'b0;
    endtask

    task automatic push_spike(input int nid);
        int n;
        n = 0;
        spk_nid   = NID_W'(nid);
        spk_valid = 1'b1;
        @(negedge clk);
        while (!spk_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!spk_ready) check("push_timeout", 64'd0, 64'd1);
        align();
        spk_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!flit_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(flit_valid), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || flit_valid || exp_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    initial begin
        int k, x0;
        logic [41:0] d0;
        logic        exp_v [6];

        repeat (3) align();
        rst = 1'b0;

        // 1: post-reset state
        @(negedge clk);
        check("rst_valid", 64'(flit_valid), 64'd0);
        check("rst_ready", 64'(spk_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data", 64'(flit_data), 64'd0);
        align();

        // 2: nid 5 -> (1,0) at t+3, then (1,1)
        rdy_force = 1'b1;
        cfg_write(5, 0, 9'h110);
        cfg_write(5, 2, 9'h111);
        push_spike(5);
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("lat_valid_%0d", i + 1), 64'(flit_valid), 64'(exp_v[i]));
            if (i == 2) check("flit_dst10", 64'(flit_data), 64'((42'd1 << 38) | 42'd5));
            if (i == 5) check("flit_dst11", 64'(flit_data),
                              64'((42'd1 << 38) | (42'd1 << 34) | 42'd5));
        end
        wait_idle("t2_idle");
        align();

        // 3: back-pressure holds the flit, single transfer on release
        rdy_force = 1'b0;
        cfg_write(7, 1, 9'h132);
        push_spike(7);
        wait_valid("t3_valid");
        d0 = flit_data;
        x0 = xfer_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_stable", 64'(flit_data), 64'(d0));
        end
        rdy_force = 1'b1;
        wait_idle("t3_idle");
        check("t3_xfers", 64'(xfer_cnt - x0), 64'd1);
        align();

        // 4: fill FIFO behind a stalled flit
        rdy_force = 1'b0;
        for (int i = 0; i < 9; i++) cfg_write(10 + i, 0, {1'b1, 4'(i), 4'(i + 3)});
        for (int i = 0; i < 9; i++) push_spike(10 + i);
        @(negedge clk);
        check("t4_full", 64'(spk_ready), 64'd0);
        x0 = xfer_cnt;
        rdy_force = 1'b1;
        wait_idle("t4_idle");
        check("t4_xfers", 64'(xfer_cnt - x0), 64'd9);
        align();

        // 5: all-disabled nid costs FANOUT+1 cycles before the next spike
        cfg_write(21, 0, 9'h155);
        push_spike(20);
        push_spike(21);
        k = 1;
        for (int i = 0; i < 30 && !flit_valid; i++) begin
            @(negedge clk);
            k++;
        end
        check("t5_gap", 64'(k), 64'(FANOUT + 4));
        wait_idle("t5_idle");
        align();

        // Randomized traffic with random back-pressure and idle-time table rewrites
        for (int r = 0; r < 30; r++) begin
            int nb;
            nb = $urandom_range(3);
            for (int c = 0; c < nb; c++)
                cfg_write($urandom_range(31), $urandom_range(FANOUT - 1), 9'($urandom));
            rdy_rand = 1'b1;
            nb = $urandom_range(6, 1);
            for (int s = 0; s < nb; s++) begin
                push_spike($urandom_range(31));
                repeat ($urandom_range(2)) align();
            end
            wait_idle("rand_idle");
            rdy_rand = 1'b0;
            align();
        end

        // 6: reset while in SEND with spikes queued
        rdy_force = 1'b0;
        for (int i = 0; i < 4; i++) push_spike(7);
        wait_valid("t6_valid");
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        @(negedge clk);
        check("t6_valid", 64'(flit_valid), 64'd0);
        check("t6_data", 64'(flit_data), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_ready", 64'(spk_ready), 64'd1);
        align();
        rdy_force = 1'b1;
        x0 = xfer_cnt;
        push_spike(5);
        repeat (FANOUT + 6) @(negedge clk);
        check("t6_tbl_cleared", 64'(xfer_cnt - x0), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);
        align();

`ifdef SPIKE_TIMESTAMP_EN
        cfg_write(3, 0, 9'h122);
        k = 0;
        while (tb_cyc != 10'd1023 && k < 2000) begin
            align();
            k++;
        end
        spk_nid   = NID_W'(3);
        spk_valid = 1'b1;
        align();
        align();
        spk_valid = 1'b0;
        wait_valid("ts_valid0");
        check("ts_max", 64'(flit_data[25:16]), 64'h3ff);
        @(negedge clk);
        wait_valid("ts_valid1");
        check("ts_wrap", 64'(flit_data[25:16]), 64'd0);
        wait_idle("ts_idle");
`endif

        check("final_queue", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
